// File: rtl/rom_dl_router.sv
// ROM download router: steers the HPS index-0 byte stream to the SDRAM ports
// or the BG tile bus, stalling the HPS while a toggle handshake is in flight.
module rom_dl_router #(
    parameter logic [24:0] SP_BASE     = 25'h12000,
    parameter logic [24:0] BG_BASE     = 25'h32000,
    parameter logic [24:0] BG_END      = 25'h3A000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [17:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_busy,
    output logic        dl_done,
    output logic        err_timeout,
    output logic        err_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          p1_req_q, p1_req_d;
    logic [22:0]   p1_a_q, p1_a_d;
    logic [1:0]    p1_ds_q, p1_ds_d;
    logic [15:0]   p1_d_q, p1_d_d;
    logic          p2_req_q, p2_req_d;
    logic [17:0]   p2_a_q, p2_a_d;
    logic [1:0]    p2_ds_q, p2_ds_d;
    logic [15:0]   p2_d_q, p2_d_d;
    logic          dl_wr_q, dl_wr_d;
    logic [24:0]   dl_addr_q, dl_addr_d;
    logic [7:0]    dl_data_q, dl_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pend_q, pend_d;
    logic          dl_q, dl_d;
    logic          err_to_q, err_to_d;
    logic          err_ov_q, err_ov_d;

    logic          accept, idle, in_p1, in_p2, in_bg;
    logic          req_sel, ack_sel;
    logic [24:0]   sp_off, bg_off;

    assign accept  = ioctl_download & ioctl_wr & (ioctl_index == 8'd0);
    assign idle    = (state_q == S_IDLE);
    assign in_p1   = (ioctl_addr < SP_BASE);
    assign in_p2   = !in_p1 && (ioctl_addr < BG_BASE);
    assign in_bg   = (ioctl_addr >= BG_BASE) && (ioctl_addr < BG_END);
    assign sp_off  = ioctl_addr - SP_BASE;
    assign bg_off  = ioctl_addr - BG_BASE;
    assign req_sel = sel_q ? p2_req_q : p1_req_q;
    assign ack_sel = sel_q ? port2_ack : port1_ack;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        p1_req_d  = p1_req_q;
        p1_a_d    = p1_a_q;
        p1_ds_d   = p1_ds_q;
        p1_d_d    = p1_d_q;
        p2_req_d  = p2_req_q;
        p2_a_d    = p2_a_q;
        p2_ds_d   = p2_ds_q;
        p2_d_d    = p2_d_q;
        dl_wr_d   = 1'b0;
        dl_addr_d = dl_addr_q;
        dl_data_d = dl_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pend_d    = pend_q;
        dl_d      = ioctl_download;
        err_to_d  = err_to_q;
        err_ov_d  = err_ov_q;

        // Completion waits for the in-flight byte to retire
        if (pend_q && idle) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pend_d = 1'b0;
        end
        if (dl_q && !ioctl_download && busy_q) begin
            pend_d = 1'b1;
        end

        if (accept && !idle) begin
            err_ov_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_p1) begin
                        sel_d   = 1'b0;
                        p1_a_d  = ioctl_addr[23:1];
                        p1_ds_d = {ioctl_addr[0], ~ioctl_addr[0]};
                        p1_d_d  = {ioctl_dout, ioctl_dout};
                        busy_d  = 1'b1;
                        state_d = S_ISSUE;
                    end else if (in_p2) begin
                        sel_d   = 1'b1;
                        p2_a_d  = {sp_off[18:17], sp_off[14:0], sp_off[16]};
                        p2_ds_d = {sp_off[15], ~sp_off[15]};
                        p2_d_d  = {ioctl_dout, ioctl_dout};
                        busy_d  = 1'b1;
                        state_d = S_ISSUE;
                    end else if (in_bg) begin
                        dl_wr_d   = 1'b1;
                        dl_addr_d = bg_off;
                        dl_data_d = ioctl_dout;
                        busy_d    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (sel_q) begin
                    p2_req_d = ~p2_req_q;
                end else begin
                    p1_req_d = ~p1_req_q;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (req_sel == ack_sel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the request: realign req so the port reads idle
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                    if (sel_q) begin
                        p2_req_d = port2_ack;
                    end else begin
                        p1_req_d = port1_ack;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            p1_req_q  <= port1_ack;
            p1_a_q    <= '0;
            p1_ds_q   <= '0;
            p1_d_q    <= '0;
            p2_req_q  <= port2_ack;
            p2_a_q    <= '0;
            p2_ds_q   <= '0;
            p2_d_q    <= '0;
            dl_wr_q   <= 1'b0;
            dl_addr_q <= '0;
            dl_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            dl_q      <= 1'b0;
            err_to_q  <= 1'b0;
            err_ov_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            p1_req_q  <= p1_req_d;
            p1_a_q    <= p1_a_d;
            p1_ds_q   <= p1_ds_d;
            p1_d_q    <= p1_d_d;
            p2_req_q  <= p2_req_d;
            p2_a_q    <= p2_a_d;
            p2_ds_q   <= p2_ds_d;
            p2_d_q    <= p2_d_d;
            dl_wr_q   <= dl_wr_d;
            dl_addr_q <= dl_addr_d;
            dl_data_q <= dl_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            dl_q      <= dl_d;
            err_to_q  <= err_to_d;
            err_ov_q  <= err_ov_d;
        end
    end

    assign ioctl_wait = ~reset & ((idle & accept & (in_p1 | in_p2))
                      | (state_q == S_ISSUE)
                      | ((state_q == S_WAIT) & (req_sel != ack_sel)));

    assign port1_req   = p1_req_q;
    assign port1_a     = p1_a_q;
    assign port1_ds    = p1_ds_q;
    assign port1_d     = p1_d_q;
    assign port2_req   = p2_req_q;
    assign port2_a     = p2_a_q;
    assign port2_ds    = p2_ds_q;
    assign port2_d     = p2_d_q;
    assign dl_wr       = dl_wr_q;
    assign dl_addr     = dl_addr_q;
    assign dl_data     = dl_data_q;
    assign rom_busy    = busy_q;
    assign dl_done     = done_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: routing, handshake timing, timeout,
// overrun, download completion and reset recovery.
module tb_rom_dl_router;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req, port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack;
    logic [17:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rom_busy, dl_done, err_timeout, err_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    rom_dl_router dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack),
        .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack),
        .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_busy(rom_busy), .dl_done(dl_done),
        .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one strobe at the current cycle and runs n cycles, toggling the
    // chosen ack at the end of cycle ack_at, optionally re-strobing ov_addr
    // and dropping ioctl_download. Called #1 after a rising edge.
    task automatic send(input logic [24:0] a, input logic [7:0] d,
                        input int port, input int ack_at, input int n,
                        input int ov_at, input logic [24:0] ov_addr,
                        input int fall_at,
                        output int wc, output int t1, output int t2,
                        output int wrc, output int dc, output int di);
        logic p1, p2;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        wc = 0; t1 = 0; t2 = 0; wrc = 0; dc = 0; di = -1;
        p1 = port1_req;
        p2 = port2_req;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            if (ioctl_wait) wc++;
            if (dl_wr) wrc++;
            if (dl_done) begin
                dc++;
                if (di < 0) di = i;
            end
            if (port1_req !== p1) t1++;
            if (port2_req !== p2) t2++;
            p1 = port1_req;
            p2 = port2_req;
            @(posedge clk_sys);
            #1;
            ioctl_wr = 1'b0;
            if (i == ack_at) begin
                if (port == 1) port1_ack = ~port1_ack;
                if (port == 2) port2_ack = ~port2_ack;
            end
            if (i == ov_at) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = ov_addr;
            end
            if (i == fall_at) ioctl_download = 1'b0;
        end
    endtask

    int wc, t1, t2, wrc, dc, di;

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        port1_ack      = 1'b0;
        port2_ack      = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_wait", ioctl_wait, 0);
        check("rst_p1req", port1_req, port1_ack);
        check("rst_p2req", port2_req, port2_ack);
        check("rst_flags", {rom_busy, dl_done, err_timeout, err_overrun, dl_wr}, 0);

        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b1;

        // P1 byte, ack 4 cycles after the request toggle
        send(25'h00003, 8'hA5, 1, 5, 10, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("p1_a", port1_a, 1);
        check("p1_ds", port1_ds, 2'b10);
        check("p1_d", port1_d, 16'hA5A5);
        check("p1_toggles", t1, 1);
        check("p1_wait_cycles", wc, 6);
        check("p1_idle", port1_req, port1_ack);
        check("p1_busy", rom_busy, 1);

        // P2 byte, s=0x8001
        send(25'h1A001, 8'h77, 2, 3, 8, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("p2_a", port2_a, 18'h00002);
        check("p2_ds", port2_ds, 2'b10);
        check("p2_d", port2_d, 16'h7777);
        check("p2_toggles", {t1[7:0], t2[7:0]}, {8'd0, 8'd1});
        check("p2_wait_cycles", wc, 4);

        // P2 byte, s=0x10000
        send(25'h22000, 8'h3C, 2, 3, 8, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("p2b_a", port2_a, 18'h00001);
        check("p2b_ds", port2_ds, 2'b01);
        check("p2b_d", port2_d, 16'h3C3C);

        // BG byte
        send(25'h32010, 8'h5C, 0, -1, 4, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("bg_wr_pulses", wrc, 1);
        check("bg_addr", dl_addr, 25'h10);
        check("bg_data", dl_data, 8'h5C);
        check("bg_no_wait", wc, 0);
        check("bg_no_req", t1 + t2, 0);

        // Ack withheld
        send(25'h00020, 8'h42, 1, -1, 300, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("to_err", err_timeout, 1);
        check("to_req_eq_ack", port1_req, port1_ack);
        check("to_toggles", t1, 2);
        check("to_wait_window", (wc >= 250 && wc <= 260), 1);

        send(25'h00010, 8'h99, 1, 2, 6, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("after_to_a", port1_a, 23'h8);
        check("after_to_ds", port1_ds, 2'b01);
        check("after_to_toggles", t1, 1);
        check("after_to_wait", wc, 3);
        check("after_to_sticky", err_timeout, 1);

        // Second strobe during WAIT
        check("ov_clear", err_overrun, 0);
        send(25'h00004, 8'h11, 1, 4, 8, 1, 25'h00100, -1, wc, t1, t2, wrc, dc, di);
        check("ov_err", err_overrun, 1);
        check("ov_a_kept", port1_a, 23'h2);
        check("ov_toggles", t1, 1);
        check("ov_wait", wc, 5);

        // Download falls during WAIT
        send(25'h00006, 8'h22, 1, 4, 10, -1, 0, 2, wc, t1, t2, wrc, dc, di);
        check("fall_done_count", dc, 1);
        check("fall_done_after_ack", di > 4, 1);
        check("fall_busy_clear", rom_busy, 0);

        // Download with nothing routed
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        send(25'h00003, 8'hEE, 1, -1, 4, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("idx1_no_wait", wc, 0);
        check("idx1_no_req", t1 + t2, 0);
        ioctl_index = 8'd0;
        send(25'h3A000, 8'hEE, 0, -1, 4, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("end_drop", {wc[7:0], wrc[7:0], t1[7:0], t2[7:0]}, 0);
        check("end_not_busy", rom_busy, 0);
        send(25'h3A001, 8'hEE, 0, -1, 8, -1, 0, 0, wc, t1, t2, wrc, dc, di);
        check("norouted_no_done", dc, 0);

        // Reset mid-WAIT
        ioctl_download = 1'b1;
        send(25'h00008, 8'h33, 1, -1, 3, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("rw_in_wait", ioctl_wait, 1);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check("rw_wait", ioctl_wait, 0);
        check("rw_req", port1_req, port1_ack);
        check("rw_flags", {rom_busy, dl_done, err_timeout, err_overrun}, 0);
        check("rw_a", port1_a, 0);
        send(25'h3A002, 8'h00, 0, -1, 5, -1, 0, -1, wc, t1, t2, wrc, dc, di);
        check("rw_no_stray", t1 + t2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
